mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 16-bit memory between three requesters: core instruction fetch (if_*), core data access (dm_*), and a program loader/debug port (ld_*).
- Sits between the single-cycle core's PC/fetch path and data path on one side and the unified memory macro on the other.
- Grants one access per cycle. Returns read data one cycle after a read grant. Raises a stall to the core when a core request is not granted.
- A small mode FSM parks the core while the loader writes memory.

Parameters:
- AW, 16, address width (word address)
- DW, 16, data width
- STARVE_MAX, 4, consecutive ungranted fetch cycles after which fetch outranks data

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1=write, 0=read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  data write value
- dm_gnt  out  1  data granted this cycle
- dm_rvalid  out  1  data read data valid
- dm_rdata  out  DW  data read data
- ld_mode  in  1  loader requests exclusive ownership
- ld_req  in  1  loader write request
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write value
- ld_gnt  out  1  loader write granted
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en && !mem_we
- core_stall  out  1  (if_req && !if_gnt) || (dm_req && !dm_gnt)
- core_hold  out  1  state != RUN

Behaviour:
- Reset, asynchronous:
  - state = RUN, starve_cnt = 0, rd_tag = NONE.
  - All gnt, rvalid and mem_en/mem_we outputs are 0. rdata outputs are 0.
- Grant and memory drive:
  - Grants are combinational from the req inputs and registered state.
  - mem_en/mem_we/mem_addr/mem_wdata are muxed combinationally from the winner. Memory samples them on the next rising edge.
  - Exactly one gnt is high when any eligible request exists. mem_en = OR of the gnts.
- Mode FSM:
  - RUN: the core is eligible and the loader is not.
    - Priority is dm over if, unless starve_cnt == STARVE_MAX, in which case if wins.
    - ld_mode=1 -> DRAIN.
  - DRAIN: no grants.
    - Stays until rd_tag == NONE (at most 1 cycle).
    - Then goes to LOAD if ld_mode=1, else back to RUN.
  - LOAD: only the loader is eligible. ld_gnt = ld_req.
    - ld_mode=0 -> RUN on the next edge.
    - A ld_req in the same cycle as ld_mode=0 is still granted.
- Read return:
  - rd_tag (NONE/IF/DM) is registered on a read grant.
  - Next cycle: the matching rvalid=1 and its rdata = mem_rdata. The other rdata holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads are supported at 1 per cycle with no bubble.
- Starvation counter:
  - Increments when if_req && !if_gnt, saturating at STARVE_MAX.
  - Clears on if_gnt or !if_req.
  - Holds in DRAIN/LOAD.
- Width rules: addresses and data pass through unmodified. No address translation.
- Simultaneous if_req and dm_req with starve_cnt < STARVE_MAX:
  - dm granted; the fetch stalls and starve_cnt counts up.
  - At STARVE_MAX, the fetch is granted once and the counter clears.
- Reset mid-read: the pending rvalid is discarded (rd_tag cleared).

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding: RUN=2'd0, DRAIN=2'd1, LOAD=2'd2
  - the tag encoding: NONE=2'd0, IF=2'd1, DM=2'd2
  - default AW/DW.
- One natural sub-module, arb_starve_prio: the 2-way priority selector with saturating starvation counter.
- The FSM, return tagging and muxing stay in the top.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x0000, 0x0001, 0x0002 on consecutive cycles.
  - Response: if_gnt=1 each cycle; if_rvalid=1 one cycle later with if_rdata = mem contents; core_stall=0.
- Contention:
  - Stimulus: if_req=1 and dm_req=1 (read 0x0040) held for 6 cycles, STARVE_MAX=4.
  - Response: dm granted on cycles 0-3; fetch granted on cycle 4; dm_rvalid/if_rvalid follow with the correct tag; core_stall high on fetch-losing cycles.
- Data write then read:
  - Stimulus: dm write 0x1234 to 0x0010, then dm read 0x0010.
  - Response: mem_we=1 on the write cycle with no rvalid; next read returns dm_rdata=0x1234.
- Loader takeover:
  - Stimulus: ld_mode=1 one cycle after a dm read grant.
  - Response: DRAIN for 1 cycle delivers dm_rvalid; then LOAD. core_hold=1 and core grants are 0 while if_req=1.
  - Stimulus: loader writes 0xBEEF to 0x0000; ld_mode=0.
  - Response: RUN; fetch of 0x0000 returns 0xBEEF.
- Reset mid-read:
  - Stimulus: rst_n low in the cycle after a fetch read grant.
  - Response: if_rvalid=0, all gnt=0, state RUN, starve_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizes for the unified memory port arbiter.
package mem_arb_pkg;

   localparam int AW_DEF         = 16;
   localparam int DW_DEF         = 16;
   localparam int STARVE_MAX_DEF = 4;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_IF   = 2'd1;
   localparam logic [1:0] TAG_DM   = 2'd2;

endpackage

// File: rtl/arb_starve_prio.sv
// Two-way fixed-priority selector: hi wins unless lo has been refused STARVE_MAX
// cycles in a row, in which case lo takes one grant and its counter clears.
module arb_starve_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic hi_req,
   input  logic lo_req,
   output logic hi_gnt,
   output logic lo_gnt
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   assign starved = (starve_cnt == CW'(STARVE_MAX));
   assign lo_gnt  = en && lo_req && (!hi_req || starved);
   assign hi_gnt  = en && hi_req && !lo_gnt;

   // The counter is frozen whenever the selector is disabled (core parked).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (en) begin
         if (!lo_req || lo_gnt)
            starve_cnt <= '0;
         else if (!starved)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch, data and loader ports,
// with a mode FSM that drains outstanding reads before handing the memory to the loader.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   input  logic          ld_mode,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          core_stall,
   output logic          core_hold
);

   logic [1:0]    state, state_nxt;
   logic [1:0]    rd_tag, rd_tag_nxt;
   logic [DW-1:0] if_rdata_q, dm_rdata_q;
   logic          core_en;

   // Grants are gated by rst_n so nothing reaches the memory while reset is held.
   assign core_en = rst_n && (state == ST_RUN);
   assign ld_gnt  = rst_n && (state == ST_LOAD) && ld_req;

   arb_starve_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (core_en),
      .hi_req (dm_req),
      .lo_req (if_req),
      .hi_gnt (dm_gnt),
      .lo_gnt (if_gnt)
   );

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ld_gnt) begin
         mem_we    = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (dm_gnt) begin
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   assign mem_en     = if_gnt || dm_gnt || ld_gnt;
   assign core_stall = (if_req && !if_gnt) || (dm_req && !dm_gnt);
   assign core_hold  = (state != ST_RUN);

   always_comb begin
      rd_tag_nxt = TAG_NONE;
      if (if_gnt)
         rd_tag_nxt = TAG_IF;
      else if (dm_gnt && !dm_we)
         rd_tag_nxt = TAG_DM;
   end

   // DRAIN waits for the single outstanding read to return before the loader owns memory.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (ld_mode) state_nxt = ST_DRAIN;
         ST_DRAIN: if (rd_tag == TAG_NONE) state_nxt = ld_mode ? ST_LOAD : ST_RUN;
         ST_LOAD:  if (!ld_mode) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   assign if_rvalid = (rd_tag == TAG_IF);
   assign dm_rvalid = (rd_tag == TAG_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
   assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         rd_tag     <= TAG_NONE;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state  <= state_nxt;
         rd_tag <= rd_tag_nxt;
         if (if_rvalid) if_rdata_q <= mem_rdata;
         if (dm_rvalid) dm_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic checked against a
// cycle-level reference model of the arbitration rules and a shadow memory.
module tb_mem_port_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we, ld_mode, ld_req;
   logic [15:0] if_addr, dm_addr, dm_wdata, ld_addr, ld_wdata;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt;
   logic [15:0] if_rdata, dm_rdata;
   logic        mem_en, mem_we, core_stall, core_hold;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   int          tests = 0;
   int          fails = 0;

   int          m_mode;
   int          m_starve;
   logic        p_if, p_dm;
   logic [15:0] p_data, last_if, last_dm;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(16), .DW(16), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .ld_mode(ld_mode), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .core_stall(core_stall), .core_hold(core_hold)
   );

   // Behavioural single-port synchronous memory.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic modelReset();
      m_mode   = 0;
      m_starve = 0;
      p_if     = 1'b0;
      p_dm     = 1'b0;
      p_data   = 16'h0;
      last_if  = 16'h0;
      last_dm  = 16'h0;
   endtask

   // Runs one clock with the current inputs: checks at negedge, then advances the model.
   task automatic stepCycle();
      logic e_if, e_dm, e_ld, e_any, n_if, n_dm, drain_done;
      logic [15:0] n_data;
      @(negedge clk);
      e_if  = (m_mode == 0) && if_req && (!dm_req || (m_starve == SM));
      e_dm  = (m_mode == 0) && dm_req && !e_if;
      e_ld  = (m_mode == 2) && ld_req;
      e_any = e_if || e_dm || e_ld;
      checkOutput("if_gnt", if_gnt, e_if);
      checkOutput("dm_gnt", dm_gnt, e_dm);
      checkOutput("ld_gnt", ld_gnt, e_ld);
      checkOutput("mem_en", mem_en, e_any);
      checkOutput("core_stall", core_stall, (if_req && !e_if) || (dm_req && !e_dm));
      checkOutput("core_hold", core_hold, m_mode != 0);
      checkOutput("if_rvalid", if_rvalid, p_if);
      checkOutput("dm_rvalid", dm_rvalid, p_dm);
      checkOutput("if_rdata", if_rdata, p_if ? p_data : last_if);
      checkOutput("dm_rdata", dm_rdata, p_dm ? p_data : last_dm);
      if (e_any) begin
         checkOutput("mem_we", mem_we, e_ld || (e_dm && dm_we));
         checkOutput("mem_addr", mem_addr, e_ld ? ld_addr : (e_dm ? dm_addr : if_addr));
         if (e_ld || (e_dm && dm_we))
            checkOutput("mem_wdata", mem_wdata, e_ld ? ld_wdata : dm_wdata);
      end

      if (p_if) last_if = p_data;
      if (p_dm) last_dm = p_data;
      drain_done = !(p_if || p_dm);
      n_if   = e_if;
      n_dm   = e_dm && !dm_we;
      n_data = 16'h0;
      if (n_if) n_data = ref_mem[if_addr];
      if (n_dm) n_data = ref_mem[dm_addr];
      if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
      if (e_ld)          ref_mem[ld_addr] = ld_wdata;
      if (m_mode == 0) begin
         if (!if_req || e_if) m_starve = 0;
         else if (m_starve < SM) m_starve++;
      end
      case (m_mode)
         0: if (ld_mode) m_mode = 1;
         1: if (drain_done) m_mode = ld_mode ? 2 : 0;
         default: if (!ld_mode) m_mode = 0;
      endcase
      p_if   = n_if;
      p_dm   = n_dm;
      p_data = n_data;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ifr, input logic [15:0] ifa,
                                input logic dmr, input logic dmw, input logic [15:0] dma,
                                input logic [15:0] dmd, input logic ldm, input logic ldr,
                                input logic [15:0] lda, input logic [15:0] ldd);
      if_req = ifr;  if_addr = ifa;
      dm_req = dmr;  dm_we = dmw;  dm_addr = dma;  dm_wdata = dmd;
      ld_mode = ldm; ld_req = ldr; ld_addr = lda; ld_wdata = ldd;
      stepCycle();
   endtask

   // Asserts reset mid-cycle and checks that outputs clear without waiting for an edge.
   task automatic pulseReset();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_if_rvalid", if_rvalid, 1'b0);
      checkOutput("rst_dm_rvalid", dm_rvalid, 1'b0);
      checkOutput("rst_if_gnt", if_gnt, 1'b0);
      checkOutput("rst_dm_gnt", dm_gnt, 1'b0);
      checkOutput("rst_ld_gnt", ld_gnt, 1'b0);
      checkOutput("rst_mem_en", mem_en, 1'b0);
      checkOutput("rst_core_hold", core_hold, 1'b0);
      checkOutput("rst_if_rdata", if_rdata, 16'h0);
      checkOutput("rst_dm_rdata", dm_rdata, 16'h0);
      modelReset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'(i * 7 + 16'h0100);
         ref_mem[i] = 16'(i * 7 + 16'h0100);
      end
      if_req = 0; dm_req = 0; dm_we = 0; ld_mode = 0; ld_req = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0; ld_addr = 0; ld_wdata = 0;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("init_mem_en", mem_en, 1'b0);
      checkOutput("init_if_rvalid", if_rvalid, 1'b0);
      checkOutput("init_core_hold", core_hold, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] fetch only");
      for (int a = 0; a < 3; a++)
         applyStimulus(1, 16'(a), 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] contention");
      for (int c = 0; c < 6; c++)
         applyStimulus(1, 16'h0008, 1, 0, 16'h0040, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] data write then read");
      applyStimulus(0, 0, 1, 1, 16'h0010, 16'h1234, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] loader takeover");
      applyStimulus(0, 0, 1, 0, 16'h0020, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 16'h0004, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 16'h0004, 1, 0, 16'h0021, 0, 1, 1, 16'h0000, 16'hBEEF);
      applyStimulus(1, 16'h0004, 0, 0, 0, 0, 0, 1, 16'h0001, 16'hCAFE);
      applyStimulus(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] reset mid-read");
      for (int c = 0; c < 3; c++)
         applyStimulus(1, 16'h0030, 1, 0, 16'h0031, 0, 0, 0, 0, 0);
      pulseReset();
      applyStimulus(1, 16'h0005, 0, 0, 0, 0, 0, 0, 0, 0);
      pulseReset();
      for (int c = 0; c < 6; c++)
         applyStimulus(1, 16'h0006, 1, 0, 16'h0007, 0, 0, 0, 0, 0);

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         logic ldm_r;
         ldm_r = ld_mode;
         if ($urandom_range(0, 24) == 0) ldm_r = !ldm_r;
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 31)), 16'($urandom),
                       ldm_r, 1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 31)), 16'($urandom));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
